// File: rtl/gf_mixcol_seq.sv
// Sequential GF(2^W) MixColumns / InvMixColumns engine for S-AES.
// Four bit-serial MSB-first multiply-accumulators process one column per WIDTH cycles.
module gf_mixcol_seq #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(4'h3),
  parameter int               NCOL  = 2,
  parameter logic [WIDTH-1:0] FWD_A = WIDTH'(1),
  parameter logic [WIDTH-1:0] FWD_B = WIDTH'(4),
  parameter logic [WIDTH-1:0] INV_A = WIDTH'(9),
  parameter logic [WIDTH-1:0] INV_B = WIDTH'(2)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    inv,
  input  logic [2*NCOL*WIDTH-1:0] state_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*NCOL*WIDTH-1:0] state_out
);

  localparam int SW = 2 * NCOL * WIDTH;
  localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  typedef enum logic [1:0] {IDLE, CALC, DONE} fsm_e;

  fsm_e                   fsm_q, fsm_d;
  logic [SW-1:0]          op_q, op_d;
  logic                   inv_q, inv_d;
  logic [CW-1:0]          col_q, col_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [3:0][WIDTH-1:0]  acc_q, acc_d;
  logic [SW-1:0]          out_q, out_d;

  logic [WIDTH-1:0]       coef_a, coef_b, s0, s1;
  logic [3:0][WIDTH-1:0]  prod;
  logic                   last_bit, last_col;

  function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] v);
    xtime = {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY : '0);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= IDLE;
      op_q  <= '0;
      inv_q <= 1'b0;
      col_q <= '0;
      bit_q <= '0;
      acc_q <= '0;
      out_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      op_q  <= op_d;
      inv_q <= inv_d;
      col_q <= col_d;
      bit_q <= bit_d;
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign last_bit = (bit_q == '0);
  assign last_col = (col_q == CW'(NCOL - 1));

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:    if (in_valid) fsm_d = CALC;
      CALC:    if (last_bit && last_col) fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (fsm_q == IDLE);
    out_valid = (fsm_q == DONE);
    state_out = out_q;
  end

  // Operand select for the active column and one MAC step for all four products.
  always_comb begin
    s0 = '0;
    s1 = '0;
    for (int c = 0; c < NCOL; c++) begin
      if (col_q == CW'(c)) begin
        s0 = op_q[(NCOL-c)*2*WIDTH-1 -: WIDTH];
        s1 = op_q[(NCOL-c)*2*WIDTH-WIDTH-1 -: WIDTH];
      end
    end
    coef_a  = inv_q ? INV_A : FWD_A;
    coef_b  = inv_q ? INV_B : FWD_B;
    prod[0] = xtime(acc_q[0]) ^ (coef_a[bit_q] ? s0 : '0);
    prod[1] = xtime(acc_q[1]) ^ (coef_b[bit_q] ? s1 : '0);
    prod[2] = xtime(acc_q[2]) ^ (coef_b[bit_q] ? s0 : '0);
    prod[3] = xtime(acc_q[3]) ^ (coef_a[bit_q] ? s1 : '0);
  end

  always_comb begin
    op_d  = op_q;
    inv_d = inv_q;
    col_d = col_q;
    bit_d = bit_q;
    acc_d = acc_q;
    out_d = out_q;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          op_d  = state_in;
          inv_d = inv;
          col_d = '0;
          bit_d = BW'(WIDTH - 1);
          acc_d = '0;
        end
      end
      CALC: begin
        acc_d = prod;
        bit_d = bit_q - BW'(1);
        if (last_bit) begin
          for (int c = 0; c < NCOL; c++) begin
            if (col_q == CW'(c)) begin
              out_d[(NCOL-c)*2*WIDTH-1 -: 2*WIDTH] = {prod[0] ^ prod[1], prod[2] ^ prod[3]};
            end
          end
          acc_d = '0;
          bit_d = BW'(WIDTH - 1);
          if (!last_col) col_d = col_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gf_mixcol_seq.sv
// Directed bench for gf_mixcol_seq at default parameters (GF(16), x^4+x+1, two columns).
module tb_gf_mixcol_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        inv;
  logic [15:0] state_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] state_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_q[$];
  logic [3:0]  x9_tab[16];
  logic [15:0] b2b_vec[6];

  gf_mixcol_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inv       (inv),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: schoolbook carry-less product then polynomial reduction.
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (8'(a) << i);
    for (int i = 7; i >= 4; i--) if (p[i]) p = p ^ (8'h13 << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [15:0] mixcol_ref(input logic [15:0] s, input logic iv);
    logic [3:0] a, b;
    logic [15:0] r;
    a = iv ? 4'h9 : 4'h1;
    b = iv ? 4'h2 : 4'h4;
    r[15:12] = gf_mul(a, s[15:12]) ^ gf_mul(b, s[11:8]);
    r[11:8]  = gf_mul(b, s[15:12]) ^ gf_mul(a, s[11:8]);
    r[7:4]   = gf_mul(a, s[7:4])   ^ gf_mul(b, s[3:0]);
    r[3:0]   = gf_mul(b, s[7:4])   ^ gf_mul(a, s[3:0]);
    return r;
  endfunction

  // driver: offer one state, wait for the result, complete the handshake if out_ready is high
  task automatic run_op(input logic iv, input logic [15:0] din,
                        output logic [15:0] dout, output int lat, output logic saw_ready);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    in_valid = 1'b1;
    inv      = iv;
    state_in = din;
    tick();
    in_valid  = 1'b0;
    lat       = 0;
    saw_ready = 1'b0;
    while (!out_valid && lat < 50) begin
      if (in_ready) saw_ready = 1'b1;
      tick();
      lat++;
    end
    dout = state_out;
    if (out_ready) tick();
  endtask

  initial begin
    logic [15:0] dout;
    int          lat, extra, sent, got, cyc;
    logic        busy_rdy, stable;

    x9_tab  = '{4'h0, 4'h9, 4'h1, 4'h8, 4'h2, 4'hB, 4'h3, 4'hA,
                4'h4, 4'hD, 4'h5, 4'hC, 4'h6, 4'hF, 4'h7, 4'hE};
    b2b_vec = '{16'h6C40, 16'h3743, 16'h1400, 16'hF000, 16'hA5C3, 16'h0FF0};

    rst = 1'b1; in_valid = 1'b0; inv = 1'b0; state_in = '0; out_ready = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_state_out", state_out, 16'h0000);
    tick(); tick();
    rst = 1'b0;
    tick();

    // forward, latency, busy
    run_op(1'b0, 16'h6C40, dout, lat, busy_rdy);
    check("fwd_6c40", dout, 16'h3743);
    check("fwd_latency", lat, 8);
    check("busy_in_ready", busy_rdy, 0);

    run_op(1'b1, 16'h3743, dout, lat, busy_rdy);
    check("inv_roundtrip", dout, 16'h6C40);
    run_op(1'b1, 16'h1400, dout, lat, busy_rdy);
    check("inv_1400", dout, 16'h1000);
    run_op(1'b1, 16'hF000, dout, lat, busy_rdy);
    check("inv_f000", dout, 16'hED00);
    check("inv_latency", lat, 8);

    for (int v = 0; v < 16; v++) begin
      run_op(1'b1, {4'(v), 12'h000}, dout, lat, busy_rdy);
      check($sformatf("x9_row0_%0d", v), dout[15:12], x9_tab[v]);
    end

    // backpressure with ignored input pulses
    out_ready = 1'b0;
    run_op(1'b0, 16'h6C40, dout, lat, busy_rdy);
    check("bp_latency", lat, 8);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!out_valid || state_out !== 16'h3743 || in_ready) stable = 1'b0;
      in_valid = (i % 2 == 1);
      inv      = (i % 4 >= 2);
      state_in = 16'h1234 + 16'(i * 16'h0101);
      tick();
    end
    in_valid = 1'b0;
    check("bp_stable", stable, 1);
    check("bp_data", state_out, 16'h3743);
    out_ready = 1'b1;
    check("rel_in_ready_low", in_ready, 0);
    tick();
    check("rel_out_valid", out_valid, 0);
    check("rel_in_ready", in_ready, 1);
    check("retain", state_out, 16'h3743);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) extra++;
      tick();
    end
    check("bp_single_transfer", extra, 0);

    // reset during CALC
    in_valid = 1'b1; inv = 1'b0; state_in = 16'h6C40;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("calc_busy", in_ready, 0);
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_state_out", state_out, 16'h0000);
    tick();
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) extra++;
      tick();
    end
    check("abort_no_valid", extra, 0);
    run_op(1'b0, 16'h6C40, dout, lat, busy_rdy);
    check("post_abort", dout, 16'h3743);
    check("post_abort_latency", lat, 8);

    // back-to-back, in_valid held high, alternating inv
    out_ready = 1'b1;
    sent = 0; got = 0; cyc = 0; extra = 0;
    while (got < 6 && cyc < 400) begin
      if (out_valid) begin
        if (exp_q.size() > 0) check($sformatf("b2b_%0d", got), state_out, exp_q.pop_front());
        else extra++;
        got++;
      end
      if (sent < 6) begin
        in_valid = 1'b1;
        state_in = b2b_vec[sent];
        inv      = (sent % 2 == 1);
        if (in_ready) begin
          exp_q.push_back(mixcol_ref(b2b_vec[sent], sent % 2 == 1));
          sent++;
        end
      end else begin
        in_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) extra++;
      tick();
    end
    check("b2b_count", got, 6);
    check("b2b_sent", sent, 6);
    check("b2b_extra", extra, 0);
    check("b2b_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
